// File: rtl/alarm_interval_timer_if.sv
// Timer handshake bundle between the anti-theft FSM (master) and the interval timer (slave).
// Carries the table-programming signals only when TIMER_REPROGRAM_EN is defined.
interface alarm_interval_timer_if;
  logic       startTimer;
  logic [1:0] interval;
  logic       clock1Hz;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
`ifdef TIMER_REPROGRAM_EN
  logic       progWrite;
  logic [1:0] progSel;
  logic [3:0] progValue;

  modport master (
    output startTimer, interval, progWrite, progSel, progValue,
    input  clock1Hz, expired, busy, remaining
  );
  modport slave (
    input  startTimer, interval, progWrite, progSel, progValue,
    output clock1Hz, expired, busy, remaining
  );
`else
  modport master (
    output startTimer, interval,
    input  clock1Hz, expired, busy, remaining
  );
  modport slave (
    input  startTimer, interval,
    output clock1Hz, expired, busy, remaining
  );
`endif
endinterface

// File: rtl/alarm_interval_timer.sv
// Interval timer: maps an interval select to a seconds value, counts it down on a 1 Hz tick
// and pulses expired. Define TIMER_REPROGRAM_EN to make the seconds table writable.
module alarm_interval_timer #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter logic [3:0]  T_ARM       = 4'd6,
  parameter logic [3:0]  T_DRIVER    = 4'd8,
  parameter logic [3:0]  T_PASSENGER = 4'd15,
  parameter logic [3:0]  T_ALARM     = 4'd10
) (
  input logic                    i_clock,
  input logic                    i_systemReset,
  alarm_interval_timer_if.slave  io_tmr
);

  localparam int unsigned    PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COUNT  = 2'd2;
  localparam logic [1:0] S_EXPIRE = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    r_sel;
  logic [3:0]    r_remaining;
  logic [PW-1:0] r_presc;

  logic [1:0]    w_state_nxt;
  logic [1:0]    w_sel_nxt;
  logic [3:0]    w_remaining_nxt;
  logic [3:0]    w_table_val;
  logic          w_tick;
  logic          w_start;

  assign w_start = io_tmr.startTimer;
  assign w_tick  = (r_presc == PRESC_MAX);

`ifdef TIMER_REPROGRAM_EN
  logic [3:0] r_table [4];

  // LOAD reads the registered entry, so a same-cycle write is not yet visible.
  always_ff @(posedge i_clock or posedge i_systemReset) begin
    if (i_systemReset) begin
      r_table[0] <= T_ARM;
      r_table[1] <= T_DRIVER;
      r_table[2] <= T_PASSENGER;
      r_table[3] <= T_ALARM;
    end else if (io_tmr.progWrite) begin
      r_table[io_tmr.progSel] <= io_tmr.progValue;
    end
  end

  assign w_table_val = r_table[r_sel];
`else
  always_comb begin
    w_table_val = T_ARM;
    unique case (r_sel)
      2'b00:   w_table_val = T_ARM;
      2'b01:   w_table_val = T_DRIVER;
      2'b10:   w_table_val = T_PASSENGER;
      2'b11:   w_table_val = T_ALARM;
      default: w_table_val = T_ARM;
    endcase
  end
`endif

  // A start in any state re-phases the tick so the first second is a full CLK_HZ cycles.
  always_ff @(posedge i_clock or posedge i_systemReset) begin
    if (i_systemReset) begin
      r_presc <= '0;
    end else if (w_start || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_remaining_nxt = r_remaining;
    unique case (r_state)
      S_IDLE: begin
        w_remaining_nxt = 4'd0;
        if (w_start) begin
          w_state_nxt = S_LOAD;
          w_sel_nxt   = io_tmr.interval;
        end
      end
      S_LOAD: begin
        w_remaining_nxt = w_table_val;
        if (w_start) begin
          w_sel_nxt = io_tmr.interval;
        end else if (w_table_val == 4'd0) begin
          w_state_nxt = S_EXPIRE;
        end else begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_start) begin
          w_state_nxt = S_LOAD;
          w_sel_nxt   = io_tmr.interval;
        end else if (w_tick) begin
          if (r_remaining <= 4'd1) begin
            w_remaining_nxt = 4'd0;
            w_state_nxt     = S_EXPIRE;
          end else begin
            w_remaining_nxt = r_remaining - 4'd1;
          end
        end
      end
      S_EXPIRE: begin
        w_remaining_nxt = 4'd0;
        if (w_start) begin
          w_state_nxt = S_LOAD;
          w_sel_nxt   = io_tmr.interval;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_systemReset) begin
    if (i_systemReset) begin
      r_state     <= S_IDLE;
      r_sel       <= 2'b00;
      r_remaining <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  assign io_tmr.clock1Hz  = w_tick;
  assign io_tmr.expired   = (r_state == S_EXPIRE);
  assign io_tmr.busy      = (r_state == S_LOAD) || (r_state == S_COUNT);
  assign io_tmr.remaining = r_remaining;

endmodule

// File: tb/tb_alarm_interval_timer.sv
// Directed bench for alarm_interval_timer with CLK_HZ=4; cycle 0 is the cycle whose closing
// edge samples startTimer, so the state seen in cycle n follows the n-th sampling edge.
module tb_alarm_interval_timer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   n_exp    = 0;

  always #5 clk = ~clk;

  alarm_interval_timer_if tmr ();

  alarm_interval_timer #(
    .CLK_HZ (4)
  ) dut (
    .i_clock       (clk),
    .i_systemReset (rst),
    .io_tmr        (tmr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start(input logic [1:0] sel);
    tmr.interval   = sel;
    tmr.startTimer = 1'b1;
    cyc            = 0;
    step();
    tmr.startTimer = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    tmr.startTimer = 1'b0;
    tmr.interval   = 2'b00;
`ifdef TIMER_REPROGRAM_EN
    tmr.progWrite  = 1'b0;
    tmr.progSel    = 2'b00;
    tmr.progValue  = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",      32'(tmr.busy),      0);
    check("reset_expired",   32'(tmr.expired),   0);
    check("reset_remaining", 32'(tmr.remaining), 0);
    check("reset_clock1Hz",  32'(tmr.clock1Hz),  0);
    rst = 1'b0;

    // Idle prescaler: count is 0 in the release cycle, so ticks land at k = 3, 7, 11, ...
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      check("idle_tick", 32'(tmr.clock1Hz), 32'(k % 4 == 3));
      check("idle_busy", 32'(tmr.busy), 0);
      step();
    end

    // Arming interval (6 s): full countdown then back to IDLE.
    start(2'b00);
    while (cyc <= 30) begin
      check("t1_busy",    32'(tmr.busy),     32'(cyc >= 1 && cyc <= 24));
      check("t1_expired", 32'(tmr.expired),  32'(cyc == 25));
      check("t1_tick",    32'(tmr.clock1Hz), 32'(cyc % 4 == 0));
      check("t1_remaining", 32'(tmr.remaining),
            (cyc == 1 || cyc >= 25) ? 0 : 32'(6 - (cyc - 1) / 4));
      step();
    end

    // Restart in the EXPIRE cycle: pulse still fires, next expiry 25 cycles later.
    start(2'b00);
    while (cyc <= 55) begin
      check("t5_expired", 32'(tmr.expired), 32'(cyc == 25 || cyc == 50));
      check("t5_busy",    32'(tmr.busy),    32'((cyc >= 1 && cyc <= 24) || (cyc >= 26 && cyc <= 49)));
      tmr.startTimer = (cyc == 25);
      step();
    end
    tmr.startTimer = 1'b0;

    // Driver countdown abandoned at cycle 10 for the 10 s siren interval.
    start(2'b01);
    while (cyc <= 60) begin
      check("t2_expired", 32'(tmr.expired), 32'(cyc == 51));
      check("t2_busy",    32'(tmr.busy),    32'(cyc >= 1 && cyc <= 50));
      if (cyc == 5)  check("t2_rem_drv",   32'(tmr.remaining), 7);
      if (cyc == 12) check("t2_rem_alarm", 32'(tmr.remaining), 10);
      if (cyc == 15) check("t2_rem_dec",   32'(tmr.remaining), 9);
      if (cyc == 10) begin
        tmr.interval   = 2'b11;
        tmr.startTimer = 1'b1;
      end else begin
        tmr.startTimer = 1'b0;
      end
      step();
    end

    // Asynchronous reset mid-count.
    start(2'b00);
    while (cyc < 7) step();
    check("t4_busy_pre", 32'(tmr.busy),      1);
    check("t4_rem_pre",  32'(tmr.remaining), 5);
    #2 rst = 1'b1;
    #1;
    check("t4_busy_rst", 32'(tmr.busy),      0);
    check("t4_rem_rst",  32'(tmr.remaining), 0);
    check("t4_tick_rst", 32'(tmr.clock1Hz),  0);
    #2 rst = 1'b0;
    n_exp = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (tmr.expired) n_exp++;
    end
    check("t4_no_expired", 32'(n_exp),     0);
    check("t4_busy_after", 32'(tmr.busy),  0);

`ifdef TIMER_REPROGRAM_EN
    // Zero-second entry expires right after LOAD.
    tmr.progWrite = 1'b1;
    tmr.progSel   = 2'b10;
    tmr.progValue = 4'd0;
    step();
    tmr.progWrite = 1'b0;
    start(2'b10);
    while (cyc <= 4) begin
      check("t6_zero_expired", 32'(tmr.expired), 32'(cyc == 2));
      step();
    end

    // Entry rewritten to 3 during a 2 s count: running count is unaffected.
    tmr.progWrite = 1'b1;
    tmr.progValue = 4'd2;
    step();
    tmr.progWrite = 1'b0;
    start(2'b10);
    while (cyc <= 12) begin
      check("t6_run_expired", 32'(tmr.expired), 32'(cyc == 9));
      tmr.progWrite = (cyc == 3);
      tmr.progValue = 4'd3;
      step();
    end
    tmr.progWrite = 1'b0;

    start(2'b10);
    while (cyc <= 16) begin
      check("t6_new_expired", 32'(tmr.expired), 32'(cyc == 13));
      if (cyc == 2) check("t6_new_rem", 32'(tmr.remaining), 3);
      step();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
